seg_display_scanner: RTL and testbench

//   Time-multiplexed 4-digit seven-segment display driver for the vending machine front panel.

---
 rtl/seg_display_scanner.sv | 105 ++++++++++
 tb/tb_seg_display_scanner.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_display_scanner.sv
// Time-multiplexed 4-digit seven-segment scanner: holds a BCD value, steps the digit index
// at a fixed refresh rate and drives registered active-low segment/dp patterns for that digit.
module seg_display_scanner #(
    parameter int REFRESH_DIV     = 100000,
    parameter bit LEAD_ZERO_BLANK = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] digits_in,
    input  logic [3:0]  dp_in,
    input  logic        blank,
    output logic [1:0]  digit_sel,
    output logic [6:0]  seg_n,
    output logic        dp_n,
    output logic        scan_tick
);

    localparam int            PW   = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0] TERM = PW'(REFRESH_DIV - 1);

    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_d;
    logic          presc_tc;
    logic [1:0]    sel_d;
    logic [3:0]    digit_q [4];
    logic [3:0]    dp_q;
    logic [3:0]    lz_dark;
    logic [3:0]    nib;
    logic [6:0]    seg_d;
    logic          dp_d;

    function automatic logic [6:0] decode(input logic [3:0] v);
        logic [6:0] r;
        case (v)
            4'd0:    r = 7'b1000000;
            4'd1:    r = 7'b1111001;
            4'd2:    r = 7'b0100100;
            4'd3:    r = 7'b0110000;
            4'd4:    r = 7'b0011001;
            4'd5:    r = 7'b0010010;
            4'd6:    r = 7'b0000010;
            4'd7:    r = 7'b1111000;
            4'd8:    r = 7'b0000000;
            4'd9:    r = 7'b0010000;
            default: r = 7'b0111111;
        endcase
        return r;
    endfunction

    // Held display value; load is ignored while in reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) digit_q[i] <= '0;
            dp_q <= '0;
        end else if (load) begin
            digit_q[0] <= digits_in[3:0];
            digit_q[1] <= digits_in[7:4];
            digit_q[2] <= digits_in[11:8];
            digit_q[3] <= digits_in[15:12];
            dp_q       <= dp_in;
        end
    end

    // A digit is a leading zero only if it and every higher digit are exactly 0.
    always_comb begin
        lz_dark    = '0;
        lz_dark[3] = (digit_q[3] == 4'd0);
        lz_dark[2] = lz_dark[3] && (digit_q[2] == 4'd0);
        lz_dark[1] = lz_dark[2] && (digit_q[1] == 4'd0);
        lz_dark[0] = 1'b0;
    end

    // Patterns are built from the next digit index so seg_n/dp_n line up with digit_sel.
    always_comb begin
        presc_tc = (presc_q == TERM);
        presc_d  = presc_tc ? '0 : presc_q + 1'b1;
        sel_d    = presc_tc ? digit_sel + 2'd1 : digit_sel;
        nib      = digit_q[sel_d];
        seg_d    = decode(nib);
        dp_d     = ~dp_q[sel_d];
        if (LEAD_ZERO_BLANK && lz_dark[sel_d]) seg_d = 7'h7F;
        if (blank) begin
            seg_d = 7'h7F;
            dp_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc_q   <= '0;
            digit_sel <= 2'd0;
            seg_n     <= 7'h7F;
            dp_n      <= 1'b1;
            scan_tick <= 1'b0;
        end else begin
            presc_q   <= presc_d;
            digit_sel <= sel_d;
            seg_n     <= seg_d;
            dp_n      <= dp_d;
            scan_tick <= presc_tc;
        end
    end

endmodule

// File: tb/tb_seg_display_scanner.sv
// Bench for seg_display_scanner with REFRESH_DIV=4: a cycle-count reference model plus
// directed scenarios and a randomized run; two instances cover both blanking settings.
module tb_seg_display_scanner;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load;
    logic [15:0] digits_in;
    logic [3:0]  dp_in;
    logic        blank;
    logic [1:0]  digit_sel, sel_b;
    logic [6:0]  seg_n, seg_b;
    logic        dp_n, dp_b;
    logic        scan_tick, tick_b;

    int tests = 0;
    int fails = 0;

    // Model state: edges since reset release and the value visible to the decode.
    int          m_cnt;
    logic [15:0] m_digits;
    logic [3:0]  m_dp;
    logic [1:0]  e_sel;
    logic [6:0]  e_seg, e_seg0;
    logic        e_dp, e_tick;

    always #5 clk = ~clk;

    seg_display_scanner #(.REFRESH_DIV(4), .LEAD_ZERO_BLANK(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .digits_in(digits_in), .dp_in(dp_in),
        .blank(blank), .digit_sel(digit_sel), .seg_n(seg_n), .dp_n(dp_n), .scan_tick(scan_tick)
    );

    seg_display_scanner #(.REFRESH_DIV(4), .LEAD_ZERO_BLANK(1'b0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .load(load), .digits_in(digits_in), .dp_in(dp_in),
        .blank(blank), .digit_sel(sel_b), .seg_n(seg_b), .dp_n(dp_b), .scan_tick(tick_b)
    );

    function automatic logic [6:0] ref_seg(input logic [15:0] v, input int i, input bit lzb);
        logic [3:0] d;
        if (lzb && i > 0 && (v >> (4 * i)) == 16'd0) return 7'h7F;
        d = 4'((v >> (4 * i)) & 16'hF);
        case (d)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    // Advance one clock, update the model from the inputs sampled at that edge.
    task automatic tick();
        @(posedge clk);
        if (!rst_n) begin
            m_cnt = 0; m_digits = '0; m_dp = '0;
            e_sel = 2'd0; e_seg = 7'h7F; e_seg0 = 7'h7F; e_dp = 1'b1; e_tick = 1'b0;
        end else begin
            m_cnt++;
            e_sel  = 2'((m_cnt / 4) % 4);
            e_tick = (m_cnt % 4 == 0);
            e_seg  = blank ? 7'h7F : ref_seg(m_digits, int'(e_sel), 1'b1);
            e_seg0 = blank ? 7'h7F : ref_seg(m_digits, int'(e_sel), 1'b0);
            e_dp   = blank ? 1'b1 : ~m_dp[e_sel];
            if (load) begin
                m_digits = digits_in;
                m_dp     = dp_in;
            end
        end
        #1;
    endtask

    task automatic load_value(input logic [15:0] v, input logic [3:0] d);
        load = 1'b1; digits_in = v; dp_in = d;
        tick();
        load = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++;
            if ({digit_sel, seg_n, dp_n, scan_tick} !== {2'd0, 7'h7F, 1'b1, 1'b0}) begin
                fails++;
                $display("FAIL reset cyc%0d: sel=%0d seg=%b dp=%b tick=%b, want 0/1111111/1/0",
                         i, digit_sel, seg_n, dp_n, scan_tick);
            end
        end
        rst_n = 1'b1;
        tick();
        tests++;
        if (seg_n !== 7'b1000000) begin
            fails++;
            $display("FAIL reset_release_seg: got %b want 1000000", seg_n);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            tests++;
            if ({digit_sel, seg_n, dp_n, scan_tick} !== {e_sel, e_seg, e_dp, e_tick}) begin
                fails++;
                $display("FAIL first_tick m%0d: sel=%0d seg=%b dp=%b tick=%b want %0d/%b/%b/%b",
                         m_cnt, digit_sel, seg_n, dp_n, scan_tick, e_sel, e_seg, e_dp, e_tick);
            end
        end
    endtask

    task automatic test_load_1234();
        load_value(16'h1234, 4'b0100);
        for (int i = 0; i < 20; i++) begin
            tick();
            tests++;
            if ({digit_sel, seg_n, dp_n, scan_tick} !== {e_sel, e_seg, e_dp, e_tick}) begin
                fails++;
                $display("FAIL load_1234 m%0d: sel=%0d seg=%b dp=%b tick=%b want %0d/%b/%b/%b",
                         m_cnt, digit_sel, seg_n, dp_n, scan_tick, e_sel, e_seg, e_dp, e_tick);
            end
            if (e_sel == 2'd2) begin
                tests++;
                if ({seg_n, dp_n} !== {7'b0100100, 1'b0}) begin
                    fails++;
                    $display("FAIL load_1234_digit2: seg=%b dp=%b want 0100100/0", seg_n, dp_n);
                end
            end
        end
    endtask

    task automatic test_lead_zero();
        load_value(16'h0070, 4'b0000);
        for (int i = 0; i < 20; i++) begin
            tick();
            tests++;
            if ({digit_sel, seg_n, seg_b, dp_n} !== {e_sel, e_seg, e_seg0, e_dp}) begin
                fails++;
                $display("FAIL lead_zero m%0d: sel=%0d seg=%b seg_nb=%b dp=%b want %0d/%b/%b/%b",
                         m_cnt, digit_sel, seg_n, seg_b, dp_n, e_sel, e_seg, e_seg0, e_dp);
            end
            if (e_sel == 2'd3 && m_cnt > 4) begin
                tests++;
                if ({seg_n, seg_b} !== {7'h7F, 7'b1000000}) begin
                    fails++;
                    $display("FAIL lead_zero_digit3: seg=%b seg_nb=%b want 1111111/1000000",
                             seg_n, seg_b);
                end
            end
        end
    endtask

    task automatic test_invalid_nibble();
        load_value(16'hA005, 4'b0000);
        for (int i = 0; i < 20; i++) begin
            tick();
            tests++;
            if ({digit_sel, seg_n, dp_n, scan_tick} !== {e_sel, e_seg, e_dp, e_tick}) begin
                fails++;
                $display("FAIL invalid_nib m%0d: sel=%0d seg=%b dp=%b tick=%b want %0d/%b/%b/%b",
                         m_cnt, digit_sel, seg_n, dp_n, scan_tick, e_sel, e_seg, e_dp, e_tick);
            end
        end
    endtask

    task automatic test_blank();
        load_value(16'h8888, 4'b1111);
        tick(); tick();
        blank = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            tests++;
            if ({digit_sel, seg_n, dp_n, scan_tick, seg_b} !== {e_sel, 7'h7F, 1'b1, e_tick, 7'h7F}) begin
                fails++;
                $display("FAIL blank m%0d: sel=%0d seg=%b dp=%b tick=%b want %0d/1111111/1/%b",
                         m_cnt, digit_sel, seg_n, dp_n, scan_tick, e_sel, e_tick);
            end
        end
        blank = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            tests++;
            if ({digit_sel, seg_n, dp_n} !== {e_sel, e_seg, e_dp}) begin
                fails++;
                $display("FAIL unblank m%0d: sel=%0d seg=%b dp=%b want %0d/%b/%b",
                         m_cnt, digit_sel, seg_n, dp_n, e_sel, e_seg, e_dp);
            end
        end
    endtask

    task automatic test_back_to_back();
        load_value(16'h1234, 4'b0001);
        for (int i = 0; i < 8 && (m_cnt % 4) != 3; i++) tick();
        load_value(16'h4321, 4'b1000);
        tests++;
        if ({digit_sel, seg_n, scan_tick} !== {e_sel, ref_seg(16'h1234, int'(e_sel), 1'b1), 1'b1}) begin
            fails++;
            $display("FAIL b2b_old_value: sel=%0d seg=%b tick=%b want old digit, tick=1",
                     digit_sel, seg_n, scan_tick);
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            tests++;
            if ({digit_sel, seg_n, dp_n, scan_tick} !== {e_sel, e_seg, e_dp, e_tick}) begin
                fails++;
                $display("FAIL b2b m%0d: sel=%0d seg=%b dp=%b tick=%b want %0d/%b/%b/%b",
                         m_cnt, digit_sel, seg_n, dp_n, scan_tick, e_sel, e_seg, e_dp, e_tick);
            end
        end
    endtask

    task automatic test_reset_mid_scan();
        load_value(16'h9999, 4'b0000);
        for (int i = 0; i < 16 && e_sel != 2'd2; i++) tick();
        tests++;
        if (e_sel != 2'd2) begin
            fails++;
            $display("FAIL mid_reset_wait: model sel=%0d never reached 2", e_sel);
        end
        rst_n = 1'b0;
        load  = 1'b1;
        tick();
        load  = 1'b0;
        rst_n = 1'b1;
        tests++;
        if ({digit_sel, seg_n, dp_n, scan_tick} !== {2'd0, 7'h7F, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL mid_reset: sel=%0d seg=%b dp=%b tick=%b want 0/1111111/1/0",
                     digit_sel, seg_n, dp_n, scan_tick);
        end
        for (int i = 0; i < 16; i++) begin
            tick();
            tests++;
            if ({digit_sel, seg_n, dp_n} !== {e_sel, (e_sel == 2'd0) ? 7'b1000000 : 7'h7F, 1'b1}) begin
                fails++;
                $display("FAIL post_reset m%0d: sel=%0d seg=%b dp=%b want %0d, zero/blank, 1",
                         m_cnt, digit_sel, seg_n, dp_n, e_sel);
            end
        end
    endtask

    task automatic test_random();
        logic [15:0] v;
        for (int i = 0; i < 400; i++) begin
            load  = ($urandom_range(0, 7) == 0);
            for (int n = 0; n < 4; n++)
                v[n*4 +: 4] = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            digits_in = v;
            dp_in     = 4'($urandom_range(0, 15));
            blank     = ($urandom_range(0, 9) == 0);
            rst_n     = ($urandom_range(0, 99) != 0);
            tick();
            tests++;
            if ({digit_sel, seg_n, dp_n, scan_tick, sel_b, seg_b, dp_b, tick_b} !==
                {e_sel, e_seg, e_dp, e_tick, e_sel, e_seg0, e_dp, e_tick}) begin
                fails++;
                $display("FAIL random m%0d: sel=%0d seg=%b dp=%b tick=%b seg_nb=%b want %0d/%b/%b/%b/%b",
                         m_cnt, digit_sel, seg_n, dp_n, scan_tick, seg_b,
                         e_sel, e_seg, e_dp, e_tick, e_seg0);
            end
        end
        load = 1'b0; blank = 1'b0; rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; load = 1'b0; digits_in = '0; dp_in = '0; blank = 1'b0;
        m_cnt = 0; m_digits = '0; m_dp = '0;
        e_sel = '0; e_seg = 7'h7F; e_seg0 = 7'h7F; e_dp = 1'b1; e_tick = 1'b0;
        #1;
        test_reset();
        test_load_1234();
        test_lead_zero();
        test_invalid_nibble();
        test_blank();
        test_back_to_back();
        test_reset_mid_scan();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
